// File: rtl/ramb4_s16_stream_reader.sv
// Streams LEN words out of a 256x16 synchronous block RAM starting at BASE,
// with a 2-entry skid buffer between the RAM read pipeline and the consumer.
module ramb4_s16_stream_reader #(
  parameter int ADDR_W = 8,
  parameter int DATA_W = 16,
  parameter int LEN_W  = 9
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              start,
  input  logic [ADDR_W-1:0] base,
  input  logic [LEN_W-1:0]  len,
  output logic              busy,
  output logic              done,
  output logic [ADDR_W-1:0] ram_addr,
  output logic              ram_en,
  output logic              ram_we,
  output logic              ram_rst,
  input  logic [DATA_W-1:0] ram_do,
  output logic [DATA_W-1:0] m_data,
  output logic              m_valid,
  input  logic              m_ready,
  output logic              m_last
);

  typedef enum logic [1:0] {IDLE, READ, DRAIN} state_t;

  localparam logic [ADDR_W-1:0] ADDR_ONE = {{(ADDR_W-1){1'b0}}, 1'b1};
  localparam logic [LEN_W-1:0]  LEN_ONE  = {{(LEN_W-1){1'b0}}, 1'b1};
  localparam logic [LEN_W-1:0]  LEN_ZERO = '0;

  state_t            state;
  logic [ADDR_W-1:0] addr_q;
  logic [LEN_W-1:0]  issue_rem;
  logic              cap_valid;
  logic              cap_last;
  logic [DATA_W:0]   ent0;
  logic [DATA_W:0]   ent1;
  logic [1:0]        count;
  logic [2:0]        held;
  logic              pop;
  logic              issue;
  logic [DATA_W:0]   cap_word;

  // A read may only be issued if its word is guaranteed a buffer slot when it lands.
  assign pop      = (count != 2'd0) && m_ready;
  assign held     = {1'b0, count} + {2'b00, cap_valid};
  assign issue    = (state == READ) && (issue_rem != LEN_ZERO) &&
                    (held < (3'd2 + {2'b00, pop}));
  assign cap_word = {cap_last, ram_do};

  assign ram_en   = issue;
  assign ram_addr = addr_q;
  assign ram_we   = 1'b0;
  assign ram_rst  = 1'b0;
  assign m_valid  = (count != 2'd0);
  assign m_data   = ent0[DATA_W-1:0];
  assign m_last   = m_valid && ent0[DATA_W];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= IDLE;
      addr_q    <= '0;
      issue_rem <= '0;
      busy      <= 1'b0;
      done      <= 1'b0;
    end else begin
      done <= 1'b0;
      case (state)
        IDLE: begin
          if (start) begin
            if (len != LEN_ZERO) begin
              state     <= READ;
              addr_q    <= base;
              issue_rem <= len;
              busy      <= 1'b1;
            end else begin
              done <= 1'b1;
            end
          end
        end
        READ: begin
          if (issue) begin
            addr_q    <= addr_q + ADDR_ONE;
            issue_rem <= issue_rem - LEN_ONE;
            if (issue_rem == LEN_ONE) state <= DRAIN;
          end
        end
        DRAIN: begin
          if (pop && m_last) begin
            state <= IDLE;
            busy  <= 1'b0;
            done  <= 1'b1;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  // cap_valid marks the cycle RAM_DO holds the word requested one cycle earlier.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cap_valid <= 1'b0;
      cap_last  <= 1'b0;
      ent0      <= '0;
      ent1      <= '0;
      count     <= 2'd0;
    end else begin
      cap_valid <= issue;
      cap_last  <= issue && (issue_rem == LEN_ONE);
      case ({cap_valid, pop})
        2'b01: begin
          ent0  <= ent1;
          count <= count - 2'd1;
        end
        2'b10: begin
          if (count == 2'd0) ent0 <= cap_word;
          else               ent1 <= cap_word;
          count <= count + 2'd1;
        end
        2'b11: begin
          if (count == 2'd1) begin
            ent0 <= cap_word;
          end else begin
            ent0 <= ent1;
            ent1 <= cap_word;
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_ramb4_s16_stream_reader.sv
// Scoreboard bench for ramb4_s16_stream_reader with a behavioural 256x16 RAM.
module tb_ramb4_s16_stream_reader;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        start = 1'b0;
  logic [7:0]  base = 8'h00;
  logic [8:0]  len = 9'd0;
  logic        busy, done, ram_en, ram_we, ram_rst, m_valid, m_last;
  logic [7:0]  ram_addr;
  logic [15:0] ram_do = 16'h0;
  logic [15:0] m_data;
  logic        m_ready = 1'b0;

  logic [15:0] mem [256];
  logic [16:0] sb_q [$];
  logic [7:0]  addr_log [$];
  logic [16:0] exp_word;
  logic        accept;

  int n_checks = 0;
  int n_fail = 0;
  int cyc = 0;
  int issued = 0;
  int accepted = 0;
  int ram_en_total = 0;
  int beats_total = 0;
  int done_cnt = 0;
  int last_done_cyc = 0;
  int last_beat_cyc = 0;

  ramb4_s16_stream_reader #(.ADDR_W(8), .DATA_W(16), .LEN_W(9)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .base(base), .len(len),
    .busy(busy), .done(done), .ram_addr(ram_addr), .ram_en(ram_en),
    .ram_we(ram_we), .ram_rst(ram_rst), .ram_do(ram_do),
    .m_data(m_data), .m_valid(m_valid), .m_ready(m_ready), .m_last(m_last)
  );

  always #5 clk = ~clk;

  initial for (int i = 0; i < 256; i++) mem[i] = 16'hA000 + 16'(i);

  always @(posedge clk) if (ram_en) ram_do <= mem[ram_addr];

  task automatic checkOutput(input string tag, input logic [31:0] actual, input logic [31:0] expected);
    n_checks++;
    if (actual !== expected) begin
      n_fail++;
      $display("[TB] FAIL %s: got %0h expected %0h at cycle %0d", tag, actual, expected, cyc);
    end
  endtask

  // Pulses start for one edge; accepted transfers have their words queued as expected beats.
  task automatic applyStimulus(input logic [7:0] b, input logic [8:0] l, input bit accepted_start);
    @(posedge clk); #1;
    base = b; len = l; start = 1'b1;
    if (accepted_start)
      for (int i = 0; i < int'(l); i++)
        sb_q.push_back({(i == int'(l) - 1), mem[8'(int'(b) + i)]});
    @(posedge clk); #1;
    start = 1'b0;
  endtask

  task automatic waitDone(input string tag, input int budget, output int cycles);
    cycles = 0;
    do begin
      @(negedge clk);
      cycles++;
    end while (!done && cycles < budget);
    checkOutput({tag, "_done"}, done, 1);
  endtask

  // Monitor: scoreboard compare on every valid cycle, plus read-credit tracking.
  always @(negedge clk) begin
    cyc++;
    if (!rst_n) begin
      issued   = 0;
      accepted = 0;
    end else begin
      accept = m_valid && m_ready;
      if (ram_en) begin
        addr_log.push_back(ram_addr);
        checkOutput("credit", ((issued + 1 - accepted - (accept ? 1 : 0)) <= 2), 1);
        issued++;
        ram_en_total++;
      end
      if (done) begin
        done_cnt++;
        last_done_cyc = cyc;
      end
      if (m_valid) begin
        checkOutput("sb_nonempty", (sb_q.size() != 0), 1);
        if (sb_q.size() != 0) begin
          exp_word = sb_q[0];
          checkOutput(accept ? "beat_data" : "stall_data", m_data, exp_word[15:0]);
          checkOutput("beat_last", m_last, exp_word[16]);
          if (accept) begin
            void'(sb_q.pop_front());
            accepted++;
            beats_total++;
            if (m_last) last_beat_cyc = cyc;
          end
        end
      end
    end
  end

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: simulation did not finish");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    int snap_en, snap_beats, snap_done, snap_addr, cycles;

    repeat (2) @(negedge clk);
    checkOutput("rst_busy", busy, 0);
    checkOutput("rst_done", done, 0);
    checkOutput("rst_ram_en", ram_en, 0);
    checkOutput("rst_m_valid", m_valid, 0);
    checkOutput("rst_m_last", m_last, 0);
    checkOutput("rst_ram_addr", ram_addr, 0);
    checkOutput("rst_m_data", m_data, 0);
    rst_n = 1'b1;
    m_ready = 1'b1;

    // Basic transfer with latency checks.
    $display("[TB] basic transfer BASE=10 LEN=4");
    snap_en = ram_en_total; snap_beats = beats_total;
    applyStimulus(8'h10, 9'd4, 1'b1);
    @(negedge clk); #1;
    checkOutput("t1_busy", busy, 1);
    checkOutput("t1_first_en", ram_en, 1);
    checkOutput("t1_first_addr", ram_addr, 8'h10);
    checkOutput("t1_valid_c1", m_valid, 0);
    @(negedge clk); #1;
    checkOutput("t1_valid_c2", m_valid, 0);
    @(negedge clk); #1;
    checkOutput("t1_valid_c3", m_valid, 1);
    waitDone("t1", 40, cycles);
    @(negedge clk); #1;
    checkOutput("t1_done_pulse", done, 0);
    checkOutput("t1_busy_after", busy, 0);
    checkOutput("t1_en_count", ram_en_total - snap_en, 4);
    checkOutput("t1_beats", beats_total - snap_beats, 4);
    checkOutput("t1_done_delay", last_done_cyc - last_beat_cyc, 1);
    checkOutput("t1_sb_empty", sb_q.size(), 0);

    // Address wrap with sustained throughput.
    $display("[TB] wrap transfer BASE=FE LEN=4");
    snap_addr = addr_log.size();
    applyStimulus(8'hFE, 9'd4, 1'b1);
    waitDone("t2", 40, cycles);
    checkOutput("t2_cycles", cycles, 7);
    @(negedge clk); #1;
    checkOutput("t2_addr_count", addr_log.size() - snap_addr, 4);
    if (addr_log.size() - snap_addr == 4) begin
      checkOutput("t2_addr0", addr_log[snap_addr],     8'hFE);
      checkOutput("t2_addr1", addr_log[snap_addr + 1], 8'hFF);
      checkOutput("t2_addr2", addr_log[snap_addr + 2], 8'h00);
      checkOutput("t2_addr3", addr_log[snap_addr + 3], 8'h01);
    end

    // Back-pressure: toggled ready, then a long stall.
    $display("[TB] back-pressure LEN=8");
    snap_beats = beats_total;
    m_ready = 1'b0;
    applyStimulus(8'h30, 9'd8, 1'b1);
    for (int i = 0; i < 8; i++) begin
      m_ready = (i % 2 == 0);
      @(posedge clk); #1;
    end
    m_ready = 1'b0;
    repeat (10) @(posedge clk);
    @(negedge clk); #1;
    checkOutput("t3_valid_stalled", m_valid, 1);
    checkOutput("t3_no_read_full", ram_en, 0);
    checkOutput("t3_held_two", issued - accepted, 2);
    @(posedge clk); #1;
    m_ready = 1'b1;
    waitDone("t3", 60, cycles);
    @(negedge clk); #1;
    checkOutput("t3_beats", beats_total - snap_beats, 8);

    // Zero-length start.
    $display("[TB] zero-length start");
    snap_en = ram_en_total; snap_done = done_cnt;
    applyStimulus(8'h55, 9'd0, 1'b1);
    @(negedge clk); #1;
    checkOutput("t4_done", done, 1);
    checkOutput("t4_busy", busy, 0);
    repeat (4) @(negedge clk);
    #1;
    checkOutput("t4_no_en", ram_en_total - snap_en, 0);
    checkOutput("t4_done_once", done_cnt - snap_done, 1);

    // Reset in the middle of a transfer.
    $display("[TB] reset mid-transfer");
    snap_beats = beats_total;
    applyStimulus(8'h20, 9'd8, 1'b1);
    for (int i = 0; i < 50 && (beats_total - snap_beats) < 3; i++) @(negedge clk);
    #1;
    checkOutput("t5_three_beats", ((beats_total - snap_beats) >= 3), 1);
    rst_n = 1'b0;
    #1;
    checkOutput("t5_busy", busy, 0);
    checkOutput("t5_done", done, 0);
    checkOutput("t5_ram_en", ram_en, 0);
    checkOutput("t5_m_valid", m_valid, 0);
    checkOutput("t5_m_last", m_last, 0);
    checkOutput("t5_ram_addr", ram_addr, 0);
    checkOutput("t5_m_data", m_data, 0);
    sb_q.delete();
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    snap_beats = beats_total;
    applyStimulus(8'h00, 9'd2, 1'b1);
    waitDone("t5", 40, cycles);
    @(negedge clk); #1;
    checkOutput("t5_beats_after", beats_total - snap_beats, 2);

    // Start while busy must be ignored.
    $display("[TB] start while busy");
    snap_beats = beats_total; snap_done = done_cnt;
    applyStimulus(8'h40, 9'd5, 1'b1);
    base = 8'h80; len = 9'd3; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    waitDone("t6", 40, cycles);
    repeat (10) @(negedge clk);
    #1;
    checkOutput("t6_beats", beats_total - snap_beats, 5);
    checkOutput("t6_done_once", done_cnt - snap_done, 1);
    checkOutput("t6_busy", busy, 0);
    checkOutput("t6_sb_empty", sb_q.size(), 0);
    checkOutput("ram_we_tied", ram_we, 0);
    checkOutput("ram_rst_tied", ram_rst, 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
